// File: rtl/tq_row_sched_if.sv
// Command/row-issue bundle between a TU controller (master) and the
// row scheduler (slave): start/direction/size/stall in, row strobes out.
interface tq_row_sched_if #(
    parameter int IDX_W = 5
);
    logic             start_i;
    logic             inverse_i;
    logic [1:0]       size_i;
    logic             stall_i;
    logic             o_valid;
    logic             o_inverse;
    logic [IDX_W-1:0] o_row_idx;
    logic             o_first;
    logic             o_last;
    logic             o_pass;
    logic             o_busy;
    logic             o_done;

    modport master (
        output start_i, inverse_i, size_i, stall_i,
        input  o_valid, o_inverse, o_row_idx, o_first, o_last, o_pass, o_busy, o_done
    );

    modport slave (
        input  start_i, inverse_i, size_i, stall_i,
        output o_valid, o_inverse, o_row_idx, o_first, o_last, o_pass, o_busy, o_done
    );
endinterface

// File: rtl/tq_row_sched.sv
// Row-issue sequencer for a DCT/IDCT transform unit: N = 4<<size rows per pass.
// Define TQ_ROW_SCHED_PASS2_EN to add a one-cycle gap and a column pass.
module tq_row_sched #(
    parameter int IDX_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    tq_row_sched_if.slave bus
);

`ifdef TQ_ROW_SCHED_PASS2_EN
    typedef enum logic [2:0] {IDLE, PASS1, GAP, PASS2, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PASS1, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       size_q, size_d;
    logic             inverse_q, inverse_d;
    logic             in_pass;
    logic             issue;
    logic [IDX_W-1:0] last_idx;

    assign last_idx = IDX_W'((6'd4 << size_q) - 6'd1);

`ifdef TQ_ROW_SCHED_PASS2_EN
    assign in_pass = (state_q == PASS1) || (state_q == PASS2);
`else
    assign in_pass = (state_q == PASS1);
`endif

    // A row goes out on every unstalled pass cycle; stall simply freezes everything.
    assign issue = in_pass && !bus.stall_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        inverse_d = inverse_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    size_d    = bus.size_i;
                    inverse_d = bus.inverse_i;
                    cnt_d     = '0;
                    state_d   = PASS1;
                end
            end
            PASS1: begin
                if (issue) begin
                    if (cnt_q == last_idx) begin
                        cnt_d = '0;
`ifdef TQ_ROW_SCHED_PASS2_EN
                        state_d = GAP;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
`ifdef TQ_ROW_SCHED_PASS2_EN
            GAP: begin
                state_d = PASS2;
            end
            PASS2: begin
                if (issue) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            size_q    <= 2'd0;
            inverse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            inverse_q <= inverse_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    assign bus.o_valid   = issue;
    assign bus.o_row_idx = issue ? cnt_q : '0;
    assign bus.o_first   = issue && (cnt_q == '0);
    assign bus.o_last    = issue && (cnt_q == last_idx);
    assign bus.o_inverse = inverse_q;
    assign bus.o_busy    = (state_q != IDLE);
    assign bus.o_done    = (state_q == DONE);

`ifdef TQ_ROW_SCHED_PASS2_EN
    assign bus.o_pass = (state_q == PASS2);
`else
    assign bus.o_pass = 1'b0;
`endif

endmodule

// File: tb/tb_tq_row_sched.sv
// Directed bench for tq_row_sched: inputs change on the falling edge and
// outputs are sampled 1ns later, well clear of the rising edge.
module tb_tq_row_sched;
    localparam int IDX_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tq_row_sched_if #(.IDX_W(IDX_W)) bus ();

    tq_row_sched #(.IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic inv, input logic [1:0] sz, input logic stl);
        @(negedge clk);
        bus.start_i   = st;
        bus.inverse_i = inv;
        bus.size_i    = sz;
        bus.stall_i   = stl;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   bus.o_valid,   0);
        check({tag, "_inverse"}, bus.o_inverse, 0);
        check({tag, "_idx"},     bus.o_row_idx, 0);
        check({tag, "_first"},   bus.o_first,   0);
        check({tag, "_last"},    bus.o_last,    0);
        check({tag, "_pass"},    bus.o_pass,    0);
        check({tag, "_busy"},    bus.o_busy,    0);
        check({tag, "_done"},    bus.o_done,    0);
    endtask

    // One pass of n rows; cycles st_from..st_to (1-based) are stalled and
    // a stray start with flipped size/direction is pulsed at cycle start_at.
    task automatic run_pass(input int n, input logic passv, input logic invv, input logic [1:0] sz,
                            input int st_from, input int st_to, input int start_at);
        int   row;
        int   c;
        logic stl;
        row = 0;
        c   = 1;
        while (row < n) begin
            stl = (c >= st_from) && (c <= st_to);
            drive(c == start_at, ~invv, ~sz, stl);
            check("row_valid",   bus.o_valid,   stl ? 0 : 1);
            check("row_idx",     bus.o_row_idx, stl ? 0 : row);
            check("row_first",   bus.o_first,   (!stl && row == 0) ? 1 : 0);
            check("row_last",    bus.o_last,    (!stl && row == n - 1) ? 1 : 0);
            check("row_pass",    bus.o_pass,    passv);
            check("row_inverse", bus.o_inverse, invv);
            check("row_busy",    bus.o_busy,    1);
            check("row_done",    bus.o_done,    0);
            if (!stl) row++;
            c++;
        end
    endtask

    task automatic run_tu(input logic [1:0] sz, input logic invv, input int st_from, input int st_to,
                          input int start_at, input logic start_in_done);
        int n;
        n = 4 << sz;
        drive(1'b1, invv, sz, 1'b0);
        check("start_busy",  bus.o_busy,  0);
        check("start_valid", bus.o_valid, 0);
        check("start_done",  bus.o_done,  0);
        run_pass(n, 1'b0, invv, sz, st_from, st_to, start_at);
`ifdef TQ_ROW_SCHED_PASS2_EN
        drive(1'b0, ~invv, ~sz, 1'b1);
        check("gap_valid", bus.o_valid,   0);
        check("gap_idx",   bus.o_row_idx, 0);
        check("gap_busy",  bus.o_busy,    1);
        check("gap_done",  bus.o_done,    0);
        run_pass(n, 1'b1, invv, sz, 0, -1, 0);
`endif
        drive(start_in_done, ~invv, ~sz, 1'b0);
        check("done_pulse",   bus.o_done,    1);
        check("done_valid",   bus.o_valid,   0);
        check("done_busy",    bus.o_busy,    1);
        check("done_inverse", bus.o_inverse, invv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.inverse_i = 1'b0;
        bus.size_i    = 2'd0;
        bus.stall_i   = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 4x4 forward TU starting on the first edge after reset release,
        // then back-to-back TUs immediately after each done pulse.
        run_tu(2'd0, 1'b0, 0, -1, 0, 1'b0);
        run_tu(2'd3, 1'b1, 0, -1, 0, 1'b0);
        run_tu(2'd1, 1'b0, 3, 5, 0, 1'b0);
        run_tu(2'd2, 1'b1, 0, -1, 2, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("post_done_busy",  bus.o_busy,  0);
        check("post_done_valid", bus.o_valid, 0);
        check("post_done_done",  bus.o_done,  0);

        // Reset asserted mid-pass while row 5 of a 16-row TU is on the bus.
        drive(1'b1, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 2'd2, 1'b0);
            check("pre_rst_idx", bus.o_row_idx, i);
        end
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_done", bus.o_done, 0);
        check("rst_hold_busy", bus.o_busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0);
            check("post_rst_busy", bus.o_busy, 0);
            check("post_rst_done", bus.o_done, 0);
        end
        run_tu(2'd0, 1'b1, 2, 2, 0, 1'b0);

        drive(1'b0, 1'b0, 2'd0, 1'b0);
        check("final_busy", bus.o_busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tq_row_sched.md
TQ_ROW_SCHED -- requirements
Module: tq_row_sched

Interface
REQ-001 Parameter: IDX_W, default 5, width of the row index output (covers 32 rows).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start_i  input  1  one-cycle request to begin a transform unit (TU).
REQ-005 Port: inverse_i  input  1  0 = forward DCT, 1 = inverse DCT; sampled with start_i.
REQ-006 Port: size_i  input  2  TU size code: 0=4x4, 1=8x8, 2=16x16, 3=32x32; sampled with start_i.
REQ-007 Port: stall_i  input  1  downstream not ready; holds sequencing.
REQ-008 Port: o_valid  output  1  row-issue strobe; drives i_valid of the DCT/IDCT valid splitter.
REQ-009 Port: o_inverse  output  1  latched direction; drives i_inverse of the splitter; stable for the whole TU.
REQ-010 Port: o_row_idx  output  IDX_W  index of the row issued with o_valid.
REQ-011 Port: o_first / o_last  output  1 each  qualify first/last row of a pass; meaningful only with o_valid=1.
REQ-012 Port: o_pass  output  1  0 = row pass, 1 = column pass.
REQ-013 Port: o_busy  output  1  high from cycle after start acceptance until done pulse inclusive.
REQ-014 Port: o_done  output  1  one-cycle pulse at TU completion.

Function
REQ-015 FSM states: IDLE, PASS1, GAP, PASS2, DONE (GAP/PASS2 exist only per REQ-031).
REQ-016 start_i accepted only in IDLE; start_i in any other state is ignored with no side effect.
REQ-017 On acceptance, inverse_i and size_i latched; row count N = 4 << size; FSM -> PASS1 next cycle.
REQ-018 Latency: start_i at cycle T gives first o_valid at T+1 when stall_i=0.
REQ-019 In PASS1/PASS2, each cycle with stall_i=0: o_valid=1, o_row_idx = counter, counter increments.
REQ-020 In PASS1/PASS2, cycle with stall_i=1: o_valid=0, counter and state hold; no row lost or duplicated.
REQ-021 o_first=1 when issued index = 0; o_last=1 when issued index = N-1; both 1 never (N>=4).
REQ-022 After the row with index N-1 issues, counter clears to 0 and FSM leaves the pass next cycle.
REQ-023 GAP lasts exactly one cycle, o_valid=0 regardless of stall_i, then -> PASS2 with o_pass=1.
REQ-024 DONE lasts exactly one cycle: o_done=1, o_valid=0, then -> IDLE; start_i in DONE is ignored.
REQ-025 o_inverse and o_pass change only on start acceptance / pass transition, never mid-pass.
REQ-026 o_row_idx = 0 whenever o_valid=0 (no stale index).
REQ-027 Counter never exceeds N-1; size latched value governs, changes on size_i mid-TU ignored.

Reset
REQ-028 rst_n low asynchronously forces IDLE, counter 0, all outputs 0 (o_valid, o_inverse, o_row_idx, o_first, o_last, o_pass, o_busy, o_done).
REQ-029 Reset asserted mid-TU aborts the TU; no o_done issued; after release, block waits for a new start_i.
REQ-030 First start_i accepted is the one sampled on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro TQ_ROW_SCHED_PASS2_EN defined: sequence IDLE->PASS1->GAP->PASS2->DONE, column pass issues N more rows with o_pass=1.
REQ-032 Macro undefined: sequence IDLE->PASS1->DONE, GAP/PASS2 absent, o_pass tied 0; all other requirements unchanged.

Verification
REQ-033 Reset, start_i=1, size_i=0, inverse_i=0, stall_i=0 at T -> o_valid T+1..T+4 with idx 0..3, o_first at T+1, o_last at T+4; without macro o_done at T+5; with macro GAP at T+5, PASS2 idx 0..3 at T+6..T+9, o_done at T+10.
REQ-034 size_i=3, inverse_i=1 -> 32 rows idx 0..31, o_inverse=1 throughout, o_busy high until o_done cycle inclusive.
REQ-035 size_i=1, stall_i=1 during cycles 3-5 of PASS1 -> o_valid=0 those cycles, idx sequence 0..7 unbroken, pass completes 3 cycles later.
REQ-036 start_i pulsed in PASS1 and in DONE with different size/inverse -> ignored; current TU unchanged, block returns to IDLE.
REQ-037 rst_n low at row 5 of a size_i=2 TU -> all outputs 0 same cycle (asynchronous), no o_done; new start_i after release runs normally.
REQ-038 Back-to-back: start_i in cycle immediately after o_done -> accepted, first o_valid next cycle.
